// File: rtl/calc_pkg.sv
// calc_pkg: key codes, op/state enums and width helpers shared by the calculator core.
package calc_pkg;
  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;
  typedef enum logic [1:0] {ADD, SUB, MUL, DIV} op_t;
  typedef enum logic [2:0] {ENTER_A, ENTER_B, CONV, CALC, TOBCD, SHOW} state_t;
  function automatic longint unsigned pow10(input int d);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < 8; i++) if (i < d) p = p * 64'd10;
    return p;
  endfunction
  function automatic int calc_w(input int d);
    int w;
    w = 0;
    for (int i = 0; i < 40; i++) if ((64'd1 << i) < pow10(d)) w = i + 1;
    return w;
  endfunction
  function automatic longint unsigned calc_limit(input int d);
    return pow10(d) - 64'd1;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: serial double-dabble; o_done/o_bcd present the final step W cycles after i_start.
module bin2bcd_seq import calc_pkg::*; #(
  parameter int DIGITS = 4,
  localparam int W = calc_w(DIGITS),
  localparam int CW = $clog2(W + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [W-1:0]        i_bin,
  output logic                o_done,
  output logic [4*DIGITS-1:0] o_bcd
);
  logic [W-1:0] r_bin;
  logic [4*DIGITS-1:0] r_bcd, w_adj;
  logic [CW-1:0] r_cnt;
  always_comb
    for (int i = 0; i < DIGITS; i++)
      w_adj[4*i +: 4] = r_bcd[4*i +: 4] > 4'd4 ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
  // o_bcd is the next-step value so the caller can capture it on the last step edge
  assign o_bcd = (w_adj << 1) | (4*DIGITS)'(r_bin[W-1]);
  assign o_done = r_cnt == CW'(1);
  always_ff @(posedge clk)
    if (rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= CW'(W);
    end else if (r_cnt != '0) begin
      r_bin <= r_bin << 1;
      r_bcd <= o_bcd;
      r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: rtl/calc_core.sv
// calc_core: keypad calculator core - BCD operand entry, serial convert/multiply/divide, BCD result.
module calc_core import calc_pkg::*; #(
  parameter int DIGITS = 4,
  localparam int W = calc_w(DIGITS),
  localparam int N = 4 * DIGITS,
  localparam int CW = $clog2(W + 1)
) (
  input  logic         CLOCK_50,
  input  logic         RST,
  input  logic [3:0]   key_value,
  input  logic         key_down,
  output logic         busy,
  output logic [N-1:0] disp_bcd,
  output logic         disp_neg,
  output logic         err,
  output logic         done
);
  localparam logic [3:0] DG = 4'(DIGITS);
  localparam logic [2*W-1:0] LIM = (2*W)'(calc_limit(DIGITS));
  state_t r_state;
  op_t r_op, w_key_op;
  logic [N-1:0] r_a_bcd, r_b_bcd, r_disp, w_a_sh, w_b_sh, w_cvt_bcd;
  logic [3:0] r_a_cnt, r_b_cnt;
  logic [W-1:0] r_a, r_b, w_a_cv, w_b_cv, w_diff, w_bin;
  logic [2*W-1:0] r_p, w_mul, w_div, w_p_nx, w_res;
  logic [W:0] w_mul_sum, w_rem;
  logic [CW-1:0] r_cnt;
  logic r_neg, r_err, r_done;
  logic w_key, w_digit, w_op, w_clr, w_ld, w_last, w_err, w_start, w_cvt_done;
  // keys are ignored in the result-valid cycle, C included
  assign w_key = key_down && !r_done;
  assign w_digit = key_value < 4'd10;
  assign w_op = key_value >= KEY_ADD && key_value <= KEY_DIV;
  assign w_key_op = op_t'(key_value[1:0] - 2'd2);
  assign w_clr = w_key && (key_value == KEY_CLR || (r_state == SHOW && w_digit));
  assign w_ld = !RST && key_value != KEY_CLR;
  assign w_a_sh = {r_a_bcd[N-5:0], key_value};
  assign w_b_sh = {r_b_bcd[N-5:0], key_value};
  assign w_a_cv = r_a * W'(10) + W'(r_a_bcd[N-1 -: 4]);
  assign w_b_cv = r_b * W'(10) + W'(r_b_bcd[N-1 -: 4]);
  // shared shift register: {acc, multiplier} for MUL, {remainder, dividend/quotient} for DIV
  assign w_mul_sum = {1'b0, r_p[2*W-1:W]} + (r_p[0] ? {1'b0, r_a} : '0);
  assign w_mul = {w_mul_sum, r_p[W-1:1]};
  assign w_rem = r_p[2*W-1:W-1];
  assign w_diff = W'(w_rem - {1'b0, r_b});
  assign w_div = w_rem < {1'b0, r_b} ? {w_rem[W-1:0], r_p[W-2:0], 1'b0} : {w_diff, r_p[W-2:0], 1'b1};
  assign w_p_nx = r_op == MUL ? w_mul : w_div;
  assign w_last = r_op == ADD || r_op == SUB || r_cnt == CW'(W - 1);
  assign w_res = r_op == ADD ? (2*W)'(r_a) + (2*W)'(r_b)
               : r_op == SUB ? (r_a >= r_b ? (2*W)'(r_a - r_b) : (2*W)'(r_b - r_a))
               : r_op == MUL ? w_p_nx : {{W{1'b0}}, w_p_nx[W-1:0]};
  assign w_err = w_res > LIM || (r_op == DIV && r_b == '0);
  assign w_start = r_state == CALC && w_last;
  assign w_bin = w_err ? '0 : w_res[W-1:0];
  bin2bcd_seq #(.DIGITS(DIGITS)) u_b2b (
    .clk(CLOCK_50), .rst(RST), .i_start(w_start), .i_bin(w_bin),
    .o_done(w_cvt_done), .o_bcd(w_cvt_bcd)
  );
  assign busy = r_state inside {CONV, CALC, TOBCD};
  assign disp_bcd = r_disp;
  assign disp_neg = r_neg;
  assign err = r_err;
  assign done = r_done;
  always_ff @(posedge CLOCK_50)
    if (RST || w_clr) begin
      r_state <= ENTER_A;
      r_op <= ADD;
      r_a_bcd <= w_ld ? N'(key_value) : '0;
      r_disp <= w_ld ? N'(key_value) : '0;
      r_a_cnt <= w_ld ? 4'd1 : 4'd0;
      r_b_bcd <= '0;
      r_b_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_p <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
      r_err <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ENTER_A:
          if (w_key && w_digit && r_a_cnt < DG) begin
            r_a_bcd <= w_a_sh;
            r_disp <= w_a_sh;
            r_a_cnt <= r_a_cnt + 4'd1;
          end else if (w_key && w_op) begin
            r_op <= w_key_op;
            r_b_bcd <= '0;
            r_b_cnt <= '0;
            r_state <= ENTER_B;
          end
        ENTER_B:
          if (w_key && w_digit && r_b_cnt < DG) begin
            r_b_bcd <= w_b_sh;
            r_disp <= w_b_sh;
            r_b_cnt <= r_b_cnt + 4'd1;
          end else if (w_key && w_op && r_b_cnt == '0) begin
            r_op <= w_key_op;
          end else if (w_key && key_value == KEY_EQ) begin
            r_a <= '0;
            r_b <= '0;
            r_cnt <= '0;
            r_state <= CONV;
          end
        CONV: begin
          r_a <= w_a_cv;
          r_b <= w_b_cv;
          r_a_bcd <= r_a_bcd << 4;
          r_b_bcd <= r_b_bcd << 4;
          r_p <= {{W{1'b0}}, r_op == MUL ? w_b_cv : w_a_cv};
          r_cnt <= r_cnt == CW'(DIGITS - 1) ? '0 : r_cnt + 1'b1;
          if (r_cnt == CW'(DIGITS - 1)) r_state <= CALC;
        end
        CALC: begin
          r_p <= w_p_nx;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= TOBCD;
            r_err <= w_err;
            r_neg <= r_op == SUB && r_a < r_b && !w_err;
          end
        end
        TOBCD:
          if (w_cvt_done) begin
            r_state <= SHOW;
            r_disp <= w_cvt_bcd;
            r_done <= 1'b1;
          end
        SHOW:
          if (w_key && w_op && !r_err && !r_neg) begin
            r_a_bcd <= r_disp;
            r_a_cnt <= DG;
            r_op <= w_key_op;
            r_b_bcd <= '0;
            r_b_cnt <= '0;
            r_state <= ENTER_B;
          end
        default: r_state <= ENTER_A;
      endcase
    end
endmodule
